// File: rtl/rr_arb_mux.sv
// N:1 valid/ready channel selector with round-robin, fixed-priority or forced
// arbitration, feeding a single registered output stage.
module rr_arb_mux #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 4,
  parameter bit RR_EN  = 1'b1,
  localparam int SEL_W = $clog2(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       in_valid,
  input  logic [NUM_CH*WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]       in_ready,
  input  logic                    force_en,
  input  logic [SEL_W-1:0]        force_sel,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  input  logic                    out_ready
);

  logic              out_valid_reg;
  logic [WIDTH-1:0]  out_data_reg;
  logic [SEL_W-1:0]  out_sel_reg;
  logic [SEL_W-1:0]  ptr_reg;
  logic [SEL_W-1:0]  ptr_next;
  logic [NUM_CH-1:0] grant;
  logic [SEL_W-1:0]  win_sel;
  logic [WIDTH-1:0]  win_data;
  logic [WIDTH-1:0]  masked_data [NUM_CH];
  logic              load;
  logic              xfer;

  assign load = !out_valid_reg || out_ready;

  always_comb begin
    int  idx;
    logic found;
    grant = '0;
    idx   = 0;
    found = 1'b0;
    if (force_en) begin
      // Out-of-range force_sel matches no channel, so nothing is granted.
      for (int i = 0; i < NUM_CH; i++) begin
        if (int'(force_sel) == i) grant[i] = in_valid[i];
      end
    end else if (RR_EN) begin
      for (int k = 0; k < NUM_CH; k++) begin
        idx = int'(ptr_reg) + k;
        if (idx >= NUM_CH) idx = idx - NUM_CH;
        if (!found && in_valid[idx]) begin
          grant[idx] = 1'b1;
          found      = 1'b1;
        end
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (!found && in_valid[i]) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = |in_ready;

  // Grant is one-hot, so an AND-OR mux selects the winning payload.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_mask
      assign masked_data[gi] = grant[gi] ? in_data[gi*WIDTH +: WIDTH] : '0;
    end
  endgenerate

  always_comb begin
    win_sel  = '0;
    win_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      win_data = win_data | masked_data[i];
      if (grant[i]) win_sel = SEL_W'(i);
    end
  end

  assign ptr_next = (win_sel == SEL_W'(NUM_CH - 1)) ? '0 : win_sel + SEL_W'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_sel_reg   <= '0;
      ptr_reg       <= '0;
    end else if (load) begin
      if (xfer) begin
        out_valid_reg <= 1'b1;
        out_data_reg  <= win_data;
        out_sel_reg   <= win_sel;
        if (RR_EN && !force_en) ptr_reg <= ptr_next;
      end else begin
        out_valid_reg <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_sel   = out_sel_reg;

endmodule
